// File: rtl/freq_div_pkg.sv
// Shared defaults and helpers for the multi-channel event divider.
// Optional toggle outputs are enabled with FREQ_DIV_TOGGLE_EN.
package freq_div_pkg;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DIV_OFF      = 0;

   // Low bit index of channel k inside a packed CHANNELS*WIDTH bus
   function automatic int slice_lo(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: phase counter, wrap compare, registered tick.
// Builds a toggle output when FREQ_DIV_TOGGLE_EN is defined.
module freq_div_chan
   import freq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             restart,
   input  logic             cnt_en,
   input  logic [WIDTH-1:0] div,
   output logic             tick,
   output logic [WIDTH-1:0] phase,
   output logic             busy
`ifdef FREQ_DIV_TOGGLE_EN
   ,
   output logic             tgl
`endif
);

   localparam logic [WIDTH-1:0] DIV_OFF_W = WIDTH'(DIV_OFF);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   logic [WIDTH-1:0] phase_d, phase_q;
   logic             tick_d, tick_q;
`ifdef FREQ_DIV_TOGGLE_EN
   logic             tgl_d, tgl_q;
`endif

   // A >= compare so a divisor shrunk below the current phase wraps on the next event
   always_comb begin
      phase_d = phase_q;
      tick_d  = 1'b0;
`ifdef FREQ_DIV_TOGGLE_EN
      tgl_d   = tgl_q;
`endif
      if (restart) begin
         phase_d = '0;
`ifdef FREQ_DIV_TOGGLE_EN
         tgl_d   = 1'b0;
`endif
      end else if (div == DIV_OFF_W) begin
         phase_d = '0;
      end else if (run && cnt_en) begin
         if (phase_q >= div - ONE) begin
            phase_d = '0;
            tick_d  = 1'b1;
`ifdef FREQ_DIV_TOGGLE_EN
            tgl_d   = ~tgl_q;
`endif
         end else begin
            phase_d = phase_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= '0;
         tick_q  <= 1'b0;
`ifdef FREQ_DIV_TOGGLE_EN
         tgl_q   <= 1'b0;
`endif
      end else begin
         phase_q <= phase_d;
         tick_q  <= tick_d;
`ifdef FREQ_DIV_TOGGLE_EN
         tgl_q   <= tgl_d;
`endif
      end
   end

   assign tick  = tick_q;
   assign phase = phase_q;
   assign busy  = (div != DIV_OFF_W) && run;
`ifdef FREQ_DIV_TOGGLE_EN
   assign tgl   = tgl_q;
`endif

endmodule

// File: rtl/freq_div_multi.sv
// N independent programmable event dividers sharing run/restart/reset.
// Define FREQ_DIV_TOGGLE_EN to add per-channel square-wave toggle outputs (tgl).
module freq_div_multi
   import freq_div_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int WIDTH    = DEF_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   input  logic                      restart,
   input  logic [CHANNELS-1:0]       cnt_en,
   input  logic [CHANNELS*WIDTH-1:0] div,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS*WIDTH-1:0] phase,
   output logic [CHANNELS-1:0]       busy
`ifdef FREQ_DIV_TOGGLE_EN
   ,
   output logic [CHANNELS-1:0]       tgl
`endif
);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      freq_div_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .run     (run),
         .restart (restart),
         .cnt_en  (cnt_en[k]),
         .div     (div[slice_lo(k, WIDTH) +: WIDTH]),
         .tick    (tick[k]),
         .phase   (phase[slice_lo(k, WIDTH) +: WIDTH]),
         .busy    (busy[k])
`ifdef FREQ_DIV_TOGGLE_EN
         ,
         .tgl     (tgl[k])
`endif
      );
   end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed-vector bench for freq_div_multi (4 channels, 8-bit divisors).
module tb_freq_div_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        restart;
   logic [3:0]  cnt_en;
   logic [31:0] div;
   logic [3:0]  tick;
   logic [31:0] phase;
   logic [3:0]  busy;
`ifdef FREQ_DIV_TOGGLE_EN
   logic [3:0]  tgl;
`endif

   int checks = 0;
   int errors = 0;

   freq_div_multi #(
      .CHANNELS (4),
      .WIDTH    (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .restart (restart),
      .cnt_en  (cnt_en),
      .div     (div),
      .tick    (tick),
      .phase   (phase),
      .busy    (busy)
`ifdef FREQ_DIV_TOGGLE_EN
      ,
      .tgl     (tgl)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic tgl_exp;

      // reset with all channels active and strobing
      reset   = 1'b1;
      run     = 1'b1;
      restart = 1'b0;
      cnt_en  = 4'hF;
      div     = {8'd4, 8'd3, 8'd2, 8'd1};
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("reset_tick",  32'(tick),  32'h0);
         check_val("reset_phase", phase,      32'h0);
      end
      check_val("reset_busy", 32'(busy), 32'hF);

      // ch0 div 4 every cycle; ch1 div 3 every third cycle
      reset = 1'b0;
      div   = {8'd0, 8'd0, 8'd3, 8'd4};
      for (int i = 0; i < 18; i++) begin
         cnt_en = {2'b00, (i % 3 == 0), 1'b1};
         step();
         check_val("ch0_phase", 32'(phase[7:0]),  32'((i + 1) % 4));
         check_val("ch0_tick",  32'(tick[0]),     32'((i + 1) % 4 == 0));
         check_val("ch1_phase", 32'(phase[15:8]), 32'((i / 3 + 1) % 3));
         check_val("ch1_tick",  32'(tick[1]),     32'((i % 3 == 0) && ((i / 3 + 1) % 3 == 0)));
      end
      check_val("ch2_busy_off", 32'(busy), 32'b0011);

      // ch0 from phase 2 with div 8: three events reach phase 5
      div    = {8'd0, 8'd0, 8'd3, 8'd8};
      cnt_en = 4'b0001;
      for (int i = 0; i < 3; i++) step();
      check_val("div8_phase5", 32'(phase[7:0]), 32'd5);
      // shrink divisor without an event: no wrap
      div    = {8'd0, 8'd0, 8'd3, 8'd3};
      cnt_en = 4'b0000;
      step();
      check_val("shrink_hold_phase", 32'(phase[7:0]), 32'd5);
      check_val("shrink_hold_tick",  32'(tick[0]),    32'd0);
      cnt_en = 4'b0001;
      step();
      check_val("shrink_wrap_phase", 32'(phase[7:0]), 32'd0);
      check_val("shrink_wrap_tick",  32'(tick[0]),    32'd1);

      // build phase {0,0,1,2} with ch2 at div 1, then restart with all strobes
      div    = {8'd4, 8'd1, 8'd4, 8'd4};
      cnt_en = 4'b0011;
      step();
      cnt_en = 4'b0001;
      step();
      check_val("pre_restart_phase", phase, 32'h0000_0102);
      restart = 1'b1;
      cnt_en  = 4'hF;
      step();
      check_val("restart_phase", phase,     32'h0);
      check_val("restart_tick",  32'(tick), 32'h0);
      restart = 1'b0;

      // one event on ch0/ch1, then freeze with run low
      cnt_en = 4'b0011;
      step();
      check_val("pre_freeze_phase", phase, 32'h0000_0101);
      run    = 1'b0;
      cnt_en = 4'hF;
      for (int i = 0; i < 10; i++) begin
         step();
         check_val("frozen_phase", phase,     32'h0000_0101);
         check_val("frozen_tick",  32'(tick), 32'h0);
      end
      check_val("frozen_busy", 32'(busy), 32'h0);

      // resume with ch2 disabled
      run = 1'b1;
      div = {8'd4, 8'd0, 8'd4, 8'd4};
      step();
      check_val("resume_phase", phase,     32'h0100_0202);
      check_val("resume_tick",  32'(tick), 32'h0);
      check_val("resume_busy",  32'(busy), 32'b1011);

      // ch3 div 1 with constant events: tick every cycle
      div     = {8'd1, 8'd0, 8'd4, 8'd4};
      cnt_en  = 4'b1100;
      tgl_exp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         tgl_exp = ~tgl_exp;
         check_val("div1_tick3",  32'(tick[3]),       32'd1);
         check_val("div1_phase3", 32'(phase[31:24]),  32'd0);
         check_val("off_tick2",   32'(tick[2]),       32'd0);
         check_val("off_phase2",  32'(phase[23:16]),  32'd0);
`ifdef FREQ_DIV_TOGGLE_EN
         check_val("tgl3", 32'(tgl[3]), 32'(tgl_exp));
`endif
      end
      check_val("off_busy2", 32'(busy[2]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
